// File: rtl/led_string_bit_encoder_pkg.sv
// Shared types and default timing for the WS2812-class serial line encoder.
package led_string_bit_encoder_pkg;

  localparam int unsigned PIXEL_W    = 24;
  localparam int unsigned DEF_T0H    = 16;
  localparam int unsigned DEF_T1H    = 32;
  localparam int unsigned DEF_TBIT   = 50;
  localparam int unsigned DEF_TRESET = 2400;
  localparam int unsigned DEF_CNT_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/led_string_bit_encoder_if.sv
// GRB pixel valid/ready stream from the LED controller to the bit encoder.
interface led_string_bit_encoder_if;

  logic [led_string_bit_encoder_pkg::PIXEL_W-1:0] pixel_data;
  logic                                           pixel_last;
  logic                                           pixel_valid;
  logic                                           pixel_ready;

  modport master (output pixel_data, pixel_last, pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, pixel_last, pixel_valid, output pixel_ready);

endinterface

// File: rtl/led_string_bit_encoder_timer.sv
// Loadable down-counter shared by the HIGH, LOW and LATCH phases.
// A load of N makes the phase last N cycles; o_expire marks the last one.
module led_pulse_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/led_string_bit_encoder.sv
// WS2812-class NRZ encoder: 24-bit GRB words in, MSB-first pulse-width waveform on led_o,
// followed by a latch low period and a done pulse at the end of each frame.
module led_string_bit_encoder
  import led_string_bit_encoder_pkg::*;
#(
  parameter int unsigned T0H    = DEF_T0H,
  parameter int unsigned T1H    = DEF_T1H,
  parameter int unsigned TBIT   = DEF_TBIT,
  parameter int unsigned TRESET = DEF_TRESET,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  led_string_bit_encoder_if.slave  pix,
  output logic                     led_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     underrun_o
);

  if (!((T0H < T1H) && (T1H < TBIT))) begin : g_bad_timing
    $error("led_string_bit_encoder: require T0H < T1H < TBIT");
  end

  localparam logic [CNT_W-1:0] L_T0H = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] L_T1H = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] L_L0  = CNT_W'(TBIT - T0H);
  localparam logic [CNT_W-1:0] L_L1  = CNT_W'(TBIT - T1H);
  localparam logic [CNT_W-1:0] L_RST = CNT_W'(TRESET);

  state_t               r_state, w_next;
  logic [PIXEL_W-1:0]   r_shift;
  logic [4:0]           r_idx;
  logic                 r_last, r_led, r_done, r_underrun;
  logic                 w_ready, w_take, w_load, w_shift, w_done, w_underrun, w_expire;
  logic [CNT_W-1:0]     w_load_val;

  led_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk    (wb_clk_i),
    .i_rst    (wb_rst_i),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    w_shift    = 1'b0;
    w_done     = 1'b0;
    w_underrun = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (pix.pixel_valid) begin
          w_load     = 1'b1;
          w_load_val = pix.pixel_data[PIXEL_W-1] ? L_T1H : L_T0H;
          w_next     = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_expire) begin
          w_load     = 1'b1;
          w_load_val = r_shift[PIXEL_W-1] ? L_L1 : L_L0;
          w_next     = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_expire) begin
          if (r_idx != '0) begin
            w_shift    = 1'b1;
            w_load     = 1'b1;
            w_load_val = r_shift[PIXEL_W-2] ? L_T1H : L_T0H;
            w_next     = ST_HIGH;
          end else begin
            // Final slot of bit 0: the next pixel may be taken here for a gapless chain.
            w_ready = ~r_last;
            if (!r_last && pix.pixel_valid) begin
              w_load     = 1'b1;
              w_load_val = pix.pixel_data[PIXEL_W-1] ? L_T1H : L_T0H;
              w_next     = ST_HIGH;
            end else begin
              w_load     = 1'b1;
              w_load_val = L_RST;
              w_underrun = ~r_last;
              w_next     = ST_LATCH;
            end
          end
        end
      end
      ST_LATCH: begin
        if (w_expire) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_take = w_ready & pix.pixel_valid;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_led      <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_led      <= (w_next == ST_HIGH);
      r_done     <= w_done;
      r_underrun <= w_underrun;
      if (w_take) begin
        r_shift <= pix.pixel_data;
        r_idx   <= 5'(PIXEL_W - 1);
        r_last  <= pix.pixel_last;
      end else if (w_shift) begin
        r_shift <= {r_shift[PIXEL_W-2:0], 1'b0};
        r_idx   <= r_idx - 5'd1;
      end
    end
  end

  assign pix.pixel_ready = w_ready & ~wb_rst_i;
  assign led_o           = r_led;
  assign busy_o          = (r_state != ST_IDLE);
  assign done_o          = r_done;
  assign underrun_o      = r_underrun;

endmodule

// File: tb/tb_led_string_bit_encoder.sv
// Bench for led_string_bit_encoder: directed and random frames against a cycle-level waveform model.
module tb_led_string_bit_encoder;
  import led_string_bit_encoder_pkg::*;

  localparam int M_T0H    = 16;
  localparam int M_T1H    = 32;
  localparam int M_TBIT   = 50;
  localparam int M_TRESET = 2400;
  localparam int PX_CYC   = 24 * M_TBIT;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic led_o, busy_o, done_o, underrun_o;

  led_string_bit_encoder_if pix ();

  led_string_bit_encoder #(
    .T0H(16), .T1H(32), .TBIT(50), .TRESET(2400), .CNT_W(12)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .pix        (pix),
    .led_o      (led_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .underrun_o (underrun_o)
  );

  always #10 wb_clk_i = ~wb_clk_i;

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  logic [23:0] px_data[$];
  logic        px_last[$];
  int          px_gap[$];
  logic [4:0]  exp_q[$], obs_q[$];   // {led, ready, busy, done, underrun}
  int          exp_xfers;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    px_data.delete();
    px_last.delete();
    px_gap.delete();
  endtask

  // gap: pixel 0 turns valid gap cycles after frame start; later pixels gap cycles after the previous transfer
  task automatic add_px(input logic [23:0] d, input logic l, input int gap);
    px_data.push_back(d);
    px_last.push_back(l);
    px_gap.push_back(gap);
  endtask

  function automatic void build_model();
    exp_q.delete();
    exp_xfers = 0;
    for (int k = 0; k <= px_gap[0]; k++) exp_q.push_back(5'b01000);
    for (int i = 0; i < px_data.size(); i++) begin
      logic [23:0] d;
      logic        lst;
      int          hi;
      d   = px_data[i];
      lst = px_last[i];
      exp_xfers++;
      for (int k = 0; k < PX_CYC; k++) begin
        hi = d[23 - k / M_TBIT] ? M_T1H : M_T0H;
        exp_q.push_back({((k % M_TBIT) < hi), ((k == PX_CYC - 1) && !lst), 1'b1, 1'b0, 1'b0});
      end
      if (lst || (i + 1 >= px_data.size())) begin
        for (int k = 0; k < M_TRESET; k++)
          exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, ((k == 0) && !lst)});
        exp_q.push_back(5'b01010);
        break;
      end
    end
  endfunction

  // Starts and ends just after a falling edge; cap>0 truncates the run and skips end-of-frame checks.
  task automatic run_frame(input string name, input int cap);
    int i = 0, last_xfer = 0, n_cyc, n_xfer = 0;
    int mism = 0, first_bad = -1, n_done = 0, n_un = 0, e_un = 0;
    int prev_rise = -1, hi_len = 0, bad_w = 0, bad_p = 0;
    build_model();
    n_cyc = (cap > 0 && cap < exp_q.size()) ? cap : exp_q.size();
    obs_q.delete();
    for (int c = 0; c < n_cyc; c++) begin
      pix.pixel_valid = (i < px_data.size()) && (c >= ((i == 0) ? 0 : last_xfer) + px_gap[i]);
      pix.pixel_data  = pix.pixel_valid ? px_data[i] : 24'($urandom);
      pix.pixel_last  = pix.pixel_valid ? px_last[i] : 1'($urandom);
      #1;
      obs_q.push_back({led_o, pix.pixel_ready, busy_o, done_o, underrun_o});
      if (pix.pixel_valid && pix.pixel_ready) begin
        i++;
        last_xfer = c;
        n_xfer++;
      end
      @(negedge wb_clk_i);
    end
    pix.pixel_valid = 1'b0;
    if (n_cyc < exp_q.size()) return;
    for (int k = 0; k < obs_q.size(); k++) begin
      if (obs_q[k] !== exp_q[k]) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
      if (obs_q[k][1] === 1'b1) n_done++;
      if (obs_q[k][0] === 1'b1) n_un++;
      if (exp_q[k][0]) e_un++;
      if (obs_q[k][4] === 1'b1) begin
        if (k == 0 || obs_q[k-1][4] !== 1'b1) begin
          if (prev_rise >= 0 && (k - prev_rise) != M_TBIT) bad_p++;
          prev_rise = k;
        end
        hi_len++;
      end else if (hi_len != 0) begin
        if (hi_len != M_T0H && hi_len != M_T1H) bad_w++;
        hi_len = 0;
      end
    end
    check($sformatf("%s wave mismatches (first at cycle %0d)", name, first_bad), mism, 0);
    check({name, " transfers"}, n_xfer, exp_xfers);
    check({name, " done pulses"}, n_done, 1);
    check({name, " underrun pulses"}, n_un, e_un);
    check({name, " bad pulse widths"}, bad_w, 0);
    check({name, " bad bit periods"}, bad_p, 0);
  endtask

  initial begin
    int cnt, n, bad;
    logic un;
    pix.pixel_valid = 1'b0;
    pix.pixel_data  = '0;
    pix.pixel_last  = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    #1;
    check("reset led_o", led_o, 0);
    check("reset pixel_ready", pix.pixel_ready, 0);
    check("reset busy_o", busy_o, 0);
    check("reset done_o", done_o, 0);
    check("reset underrun_o", underrun_o, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    #1;
    check("idle pixel_ready", pix.pixel_ready, 1);
    @(negedge wb_clk_i);

    // single pixel, last
    new_frame();
    add_px(24'hFF0000, 1'b1, 0);
    run_frame("t1", 0);
    cnt = 0;
    foreach (obs_q[k]) if (obs_q[k][4] === 1'b1) cnt++;
    check("t1 total high cycles", cnt, 8 * M_T1H + 16 * M_T0H);

    // two pixels, valid held high: gapless LSB -> MSB
    new_frame();
    add_px(24'h000001, 1'b0, 2);
    add_px(24'h800000, 1'b1, 1);
    run_frame("t2", 0);
    check("t2 ready in last cycle of pixel 1", obs_q[2 + PX_CYC][3], 1);
    check("t2 led low before pixel 2", obs_q[2 + PX_CYC][4], 0);
    check("t2 pixel 2 MSB rises at once", obs_q[3 + PX_CYC][4], 1);

    // underrun
    new_frame();
    add_px(24'hAAAAAA, 1'b0, 0);
    run_frame("t3", 0);
    check("t3 underrun after bit 0", obs_q[1 + PX_CYC][0], 1);

    // back-pressure mid-bit
    new_frame();
    add_px(24'h123456, 1'b0, 0);
    add_px(24'hC3C3C3, 1'b1, 300);
    run_frame("t4", 0);
    check("t4 ready low while valid mid-bit", obs_q[400][3], 0);

    // next pixel arrives exactly in the bit-0 end slot
    new_frame();
    add_px(24'h0F0F0F, 1'b0, 0);
    add_px(24'hF0F0F0, 1'b1, PX_CYC);
    run_frame("t6 boundary", 0);

    // reset during bit 10
    new_frame();
    add_px(24'h5A5A5A, 1'b1, 0);
    run_frame("t5", 1 + 10 * M_TBIT + 20);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    #1;
    check("t5 led_o after reset", led_o, 0);
    check("t5 busy_o after reset", busy_o, 0);
    check("t5 ready during reset", pix.pixel_ready, 0);
    wb_rst_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 3200; k++) begin
      @(negedge wb_clk_i);
      #1;
      if (led_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || underrun_o !== 1'b0) bad++;
    end
    @(negedge wb_clk_i);
    check("t5 quiet after abandoned pixel", bad, 0);
    new_frame();
    add_px(24'($urandom), 1'b1, 3);
    run_frame("t5 restart", 0);

    // random frames
    for (int r = 0; r < 6; r++) begin
      new_frame();
      n  = $urandom_range(1, 3);
      un = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < n; k++)
        add_px(24'($urandom), (k == n - 1) && !un, (k == 0) ? $urandom_range(0, 6) : $urandom_range(1, PX_CYC));
      run_frame($sformatf("rand%0d", r), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
